sccb_rx_request_parser: RTL and testbench

SCCB_RX_REQUEST_PARSER -- requirements
Module: sccb_rx_request_parser

---
 rtl/sccb_rx_request_parser_pkg.sv | 21 ++
 rtl/apb_if.sv | 28 ++
 rtl/sccb_rx_request_parser.sv | 172 +++++++++++++++++
 tb/tb_sccb_rx_request_parser.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_rx_request_parser_pkg.sv
// Shared SCCB link constants and parser state encoding.
// Used by both the RX request parser and the TX encoder.
package SCCB_Pkg;

    localparam logic [7:0] K28_5    = 8'hBC;  // idle
    localparam logic [7:0] K27_7    = 8'hFB;  // start of frame
    localparam logic [7:0] K29_7    = 8'hFD;  // end of frame
    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        WDATA,
        EOF,
        SETUP,
        ACCESS,
        RESP
    } state_e;

endpackage

// File: rtl/apb_if.sv
// APB bus bundle with requester and completer views.
interface apb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    pclk;
    logic                    preset_n;
    logic [ADDR_WIDTH-1:0]   paddr;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [DATA_WIDTH-1:0]   pwdata;
    logic [DATA_WIDTH/8-1:0] pstrb;
    logic [2:0]              pprot;
    logic                    pready;
    logic [DATA_WIDTH-1:0]   prdata;
    logic                    pslverr;

    modport requester (
        output pclk, preset_n, paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

    modport completer (
        input  pclk, preset_n, paddr, psel, penable, pwrite, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/sccb_rx_request_parser.sv
// Parses SCCB request frames from the 8b/10b RX lanes and replays them as single
// APB transfers, returning one completion per accepted frame.
module sccb_rx_request_parser
    import SCCB_Pkg::*;
#(
    parameter int NUM_SYMBOLS = 4,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [8*NUM_SYMBOLS-1:0] rx_data,
    input  logic [NUM_SYMBOLS-1:0]   rx_charisk,
    input  logic                     rx_valid,
    apb_if.requester                 apb_req,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [31:0]              resp_data,
    output logic                     resp_err,
    output logic                     resp_is_read,
    output logic [15:0]              drop_count,
    output logic [15:0]              err_count
);

    state_e                  state_q, state_d;
    logic                    is_write_q, is_write_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             resp_data_q, resp_data_d;
    logic                    resp_err_q, resp_err_d;
    logic                    resp_is_read_q, resp_is_read_d;
    logic                    discard_q, discard_d;
    logic [15:0]             drop_count_q, drop_count_d;
    logic [15:0]             err_count_q, err_count_d;

    logic       word_v, is_sof, is_eof, hdr_ok, err_inc, drop_inc;
    logic [7:0] opcode;

    assign opcode = rx_data[15:8];
    assign word_v = rx_valid && !discard_q;
    assign is_sof = rx_charisk[0] && (rx_data[7:0] == K27_7);
    assign is_eof = rx_charisk[0] && (rx_data[7:0] == K29_7);
    assign hdr_ok = ((opcode == OP_WRITE) || (opcode == OP_READ))
                    && (rx_charisk[NUM_SYMBOLS-1:1] == '0)
                    && (rx_data[8*NUM_SYMBOLS-1:16] == '0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d        = state_q;
        is_write_d     = is_write_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        resp_data_d    = resp_data_q;
        resp_err_d     = resp_err_q;
        resp_is_read_d = resp_is_read_q;
        discard_d      = discard_q;
        err_inc        = 1'b0;
        drop_inc       = 1'b0;

        // A dropped frame is swallowed up to and including its own K29.7.
        if (rx_valid && discard_q && is_eof)
            discard_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (word_v && is_sof) begin
                    if (hdr_ok) begin
                        state_d    = ADDR;
                        is_write_d = (opcode == OP_WRITE);
                    end else begin
                        err_inc = 1'b1;
                    end
                end
            end
            ADDR, WDATA, EOF: begin
                if (word_v) begin
                    if (is_sof) begin
                        // Truncated frame: count it and restart on the new header.
                        err_inc    = 1'b1;
                        state_d    = hdr_ok ? ADDR : IDLE;
                        is_write_d = (opcode == OP_WRITE);
                    end else if (state_q == EOF) begin
                        if (is_eof) begin
                            state_d = SETUP;
                        end else begin
                            err_inc = 1'b1;
                            state_d = IDLE;
                        end
                    end else if (rx_charisk != '0) begin
                        err_inc = 1'b1;
                        state_d = IDLE;
                    end else if (state_q == ADDR) begin
                        addr_d  = rx_data[ADDR_WIDTH-1:0];
                        state_d = is_write_q ? WDATA : EOF;
                        if (!is_write_q)
                            wdata_d = '0;
                    end else begin
                        wdata_d = rx_data[31:0];
                        state_d = EOF;
                    end
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (apb_req.pready) begin
                    resp_data_d    = is_write_q ? 32'h0 : apb_req.prdata;
                    resp_err_d     = apb_req.pslverr;
                    resp_is_read_d = !is_write_q;
                    state_d        = RESP;
                end
            end
            RESP: begin
                if (resp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (word_v && is_sof && (state_q inside {SETUP, ACCESS, RESP})) begin
            drop_inc  = 1'b1;
            discard_d = 1'b1;
        end

        drop_count_d = (drop_inc && drop_count_q != 16'hFFFF) ? drop_count_q + 16'd1 : drop_count_q;
        err_count_d  = (err_inc  && err_count_q  != 16'hFFFF) ? err_count_q  + 16'd1 : err_count_q;
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            is_write_q     <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            resp_data_q    <= '0;
            resp_err_q     <= 1'b0;
            resp_is_read_q <= 1'b0;
            discard_q      <= 1'b0;
            drop_count_q   <= '0;
            err_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            is_write_q     <= is_write_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            resp_data_q    <= resp_data_d;
            resp_err_q     <= resp_err_d;
            resp_is_read_q <= resp_is_read_d;
            discard_q      <= discard_d;
            drop_count_q   <= drop_count_d;
            err_count_q    <= err_count_d;
        end
    end

    // Bus controls decode straight from state, so reset clears psel without waiting for an edge.
    assign apb_req.pclk     = clk;
    assign apb_req.preset_n = ~rst;
    assign apb_req.psel     = (state_q == SETUP) || (state_q == ACCESS);
    assign apb_req.penable  = (state_q == ACCESS);
    assign apb_req.pwrite   = is_write_q;
    assign apb_req.paddr    = addr_q;
    assign apb_req.pwdata   = wdata_q;
    assign apb_req.pstrb    = '1;
    assign apb_req.pprot    = 3'b000;

    assign resp_valid   = (state_q == RESP);
    assign resp_data    = resp_data_q;
    assign resp_err     = resp_err_q;
    assign resp_is_read = resp_is_read_q;
    assign drop_count   = drop_count_q;
    assign err_count    = err_count_q;

endmodule

// File: tb/tb_sccb_rx_request_parser.sv
// Scoreboard bench for sccb_rx_request_parser: stimulus pushes expectations,
// negedge monitors pop and compare APB transfers and completions.
module tb_sccb_rx_request_parser;
    import SCCB_Pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rx_data;
    logic [3:0]  rx_charisk;
    logic        rx_valid;
    logic        resp_valid, resp_ready, resp_err, resp_is_read;
    logic [31:0] resp_data;
    logic [15:0] drop_count, err_count;

    apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb ();

    sccb_rx_request_parser #(.NUM_SYMBOLS(4), .ADDR_WIDTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_charisk   (rx_charisk),
        .rx_valid     (rx_valid),
        .apb_req      (apb),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .resp_is_read (resp_is_read),
        .drop_count   (drop_count),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
    } apb_exp_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic        is_read;
    } resp_exp_t;

    apb_exp_t  exp_apb[$];
    resp_exp_t exp_resp[$];
    int        exp_setup[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int          cfg_wait   = 0;
    logic [31:0] cfg_rdata  = 32'h0;
    logic        cfg_slverr = 1'b0;
    int          acc_cnt    = 0;

    apb_exp_t    mon_apb;
    int          mon_setup;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Completer model: pready rises after cfg_wait ACCESS cycles.
    assign apb.prdata  = cfg_rdata;
    assign apb.pslverr = cfg_slverr;
    always @(posedge clk) begin
        #1;
        if (apb.psel && apb.penable) begin
            apb.pready = (acc_cnt == cfg_wait);
            acc_cnt++;
        end else begin
            apb.pready = 1'b0;
            acc_cnt    = 0;
        end
    end

    // Monitor
    always @(negedge clk) begin
        if (apb.psel && !apb.penable) begin
            if (exp_setup.size() == 0) begin
                fail("unexpected_psel");
            end else begin
                mon_setup = exp_setup.pop_front();
                check("setup_latency", 32'(cyc), 32'(mon_setup + 1));
                check("pstrb", 32'(apb.pstrb), 32'hF);
                check("pprot", 32'(apb.pprot), 32'h0);
            end
        end
        if (apb.psel && apb.penable && apb.pready) begin
            if (exp_apb.size() == 0) begin
                fail("unexpected_apb_xfer");
            end else begin
                mon_apb = exp_apb.pop_front();
                check("pwrite", 32'(apb.pwrite), 32'(mon_apb.wr));
                check("paddr", apb.paddr, mon_apb.addr);
                if (mon_apb.wr)
                    check("pwdata", apb.pwdata, mon_apb.wdata);
            end
        end
        if (resp_valid) begin
            if (exp_resp.size() == 0) begin
                fail("unexpected_resp");
            end else begin
                check("resp_data", resp_data, exp_resp[0].data);
                check("resp_err", 32'(resp_err), 32'(exp_resp[0].err));
                check("resp_is_read", 32'(resp_is_read), 32'(exp_resp[0].is_read));
                if (resp_ready)
                    void'(exp_resp.pop_front());
            end
        end
    end

    // Invalid cycles carry an SOF-looking pattern that must be ignored.
    task automatic idle_cycle();
        rx_valid   = 1'b0;
        rx_data    = {16'h0, OP_WRITE, K27_7};
        rx_charisk = 4'b0001;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [31:0] d, input logic [3:0] k);
        rx_valid   = 1'b1;
        rx_data    = d;
        rx_charisk = k;
        @(posedge clk);
        #1;
        rx_valid   = 1'b0;
        rx_data    = {4{K28_5}};
        rx_charisk = 4'b1111;
    endtask

    task automatic send_frame(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                              input bit with_data, input bit track,
                              input int g0, input int g1, input int g2, input int g3);
        repeat (g0) idle_cycle();
        drive_word({16'h0, op, K27_7}, 4'b0001);
        repeat (g1) idle_cycle();
        drive_word(addr, 4'b0000);
        if (with_data) begin
            repeat (g2) idle_cycle();
            drive_word(wdata, 4'b0000);
        end
        repeat (g3) idle_cycle();
        if (track)
            exp_setup.push_back(cyc);
        drive_word({24'h0, K29_7}, 4'b0001);
    endtask

    task automatic expect_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input logic err);
        exp_apb.push_back('{wr: wr, addr: addr, wdata: wdata});
        exp_resp.push_back('{data: wr ? 32'h0 : rdata, err: err, is_read: !wr});
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while ((exp_resp.size() != 0 || exp_apb.size() != 0 || exp_setup.size() != 0) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (exp_resp.size() != 0 || exp_apb.size() != 0 || exp_setup.size() != 0)
            fail(name);
        repeat (3) idle_cycle();
    endtask

    task automatic wait_access(input string name);
        int n = 0;
        while (!(apb.psel && apb.penable) && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!(apb.psel && apb.penable))
            fail(name);
    endtask

    task automatic wait_resp_valid(input string name);
        int n = 0;
        while (!resp_valid && n < 50) begin
            idle_cycle();
            n++;
        end
        if (!resp_valid)
            fail(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = 32'h0;
        rx_charisk = 4'h0;
        resp_ready = 1'b1;
        apb.pready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_psel", 32'(apb.psel), 32'h0);
        check("reset_preset_n", 32'(apb.preset_n), 32'h0);
        rst = 1'b0;
        #1;
        check("reset_penable", 32'(apb.penable), 32'h0);
        check("reset_pwrite", 32'(apb.pwrite), 32'h0);
        check("reset_paddr", apb.paddr, 32'h0);
        check("reset_resp_valid", 32'(resp_valid), 32'h0);
        check("reset_resp_data", resp_data, 32'h0);
        check("reset_err_count", 32'(err_count), 32'h0);
        check("reset_drop_count", 32'(drop_count), 32'h0);
        check("preset_n_released", 32'(apb.preset_n), 32'h1);
        repeat (2) idle_cycle();

        // Plain write
        cfg_wait = 0; cfg_slverr = 1'b0;
        expect_xfer(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 1'b0);
        send_frame(OP_WRITE, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 1'b1, 0, 0, 0, 0);
        wait_done("write_timeout");

        // Read, 3 wait states, slave error
        cfg_wait = 3; cfg_rdata = 32'hCAFE_F00D; cfg_slverr = 1'b1;
        expect_xfer(1'b0, 32'h0000_0020, 32'h0, 32'hCAFE_F00D, 1'b1);
        send_frame(OP_READ, 32'h0000_0020, 32'h0, 1'b0, 1'b1, 0, 0, 0, 0);
        wait_done("read_timeout");

        // Bad opcode, then a good read
        send_frame(8'h07, 32'h0000_0040, 32'h0, 1'b0, 1'b0, 0, 0, 0, 0);
        repeat (3) idle_cycle();
        check("bad_op_err_count", 32'(err_count), 32'h1);
        check("bad_op_drop_count", 32'(drop_count), 32'h0);
        cfg_wait = 1; cfg_rdata = 32'h1234_5678; cfg_slverr = 1'b0;
        expect_xfer(1'b0, 32'h0000_0024, 32'h0, 32'h1234_5678, 1'b0);
        send_frame(OP_READ, 32'h0000_0024, 32'h0, 1'b1 && 1'b0, 1'b1, 0, 0, 0, 0);
        wait_done("post_bad_read_timeout");

        // Writes with rx_valid gaps
        cfg_wait = 0; cfg_slverr = 1'b0;
        expect_xfer(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 1'b0);
        send_frame(OP_WRITE, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 1'b1, 2, 5, 0, 3);
        wait_done("gap_write_a_timeout");
        expect_xfer(1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 1'b0);
        send_frame(OP_WRITE, 32'h0000_1000, 32'hDEAD_BEEF, 1'b1, 1'b1, 0, 1, 4, 5);
        wait_done("gap_write_b_timeout");

        // Second SOF during ACCESS with resp_ready low
        cfg_wait = 6; resp_ready = 1'b0;
        expect_xfer(1'b1, 32'h0000_0044, 32'h1122_3344, 32'h0, 1'b0);
        send_frame(OP_WRITE, 32'h0000_0044, 32'h1122_3344, 1'b1, 1'b1, 0, 0, 0, 0);
        wait_access("drop_access_timeout");
        send_frame(OP_WRITE, 32'h0000_0088, 32'h5555_5555, 1'b1, 1'b0, 0, 0, 0, 0);
        wait_resp_valid("drop_resp_timeout");
        repeat (4) idle_cycle();
        resp_ready = 1'b1;
        wait_done("drop_done_timeout");
        check("drop_count_access", 32'(drop_count), 32'h1);
        check("err_count_after_drop", 32'(err_count), 32'h1);

        // SOF on the completion handshake cycle
        cfg_wait = 0; resp_ready = 1'b0;
        expect_xfer(1'b1, 32'h0000_0048, 32'h0BAD_F00D, 32'h0, 1'b0);
        send_frame(OP_WRITE, 32'h0000_0048, 32'h0BAD_F00D, 1'b1, 1'b1, 0, 0, 0, 0);
        wait_resp_valid("hs_resp_timeout");
        resp_ready = 1'b1;
        send_frame(OP_WRITE, 32'h0000_004C, 32'h7777_7777, 1'b1, 1'b0, 0, 0, 0, 0);
        wait_done("hs_done_timeout");
        check("drop_count_handshake", 32'(drop_count), 32'h2);
        check("err_count_handshake", 32'(err_count), 32'h1);

        // Reset in the middle of ACCESS
        cfg_wait = 10; cfg_rdata = 32'h0F0F_0F0F;
        expect_xfer(1'b0, 32'h0000_0030, 32'h0, 32'h0F0F_0F0F, 1'b0);
        send_frame(OP_READ, 32'h0000_0030, 32'h0, 1'b0, 1'b1, 0, 0, 0, 0);
        wait_access("rst_access_timeout");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_psel", 32'(apb.psel), 32'h0);
        check("rst_penable", 32'(apb.penable), 32'h0);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_err_count", 32'(err_count), 32'h0);
        check("rst_drop_count", 32'(drop_count), 32'h0);
        exp_apb.delete();
        exp_resp.delete();
        exp_setup.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        repeat (5) idle_cycle();

        // Recovery after reset
        cfg_wait = 0; cfg_slverr = 1'b0;
        expect_xfer(1'b1, 32'h0000_2000, 32'hA5A5_A5A5, 32'h0, 1'b0);
        send_frame(OP_WRITE, 32'h0000_2000, 32'hA5A5_A5A5, 1'b1, 1'b1, 0, 0, 0, 0);
        wait_done("recovery_timeout");
        check("final_err_count", 32'(err_count), 32'h0);
        check("final_drop_count", 32'(drop_count), 32'h0);
        check("final_resp_valid", 32'(resp_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
